// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch slice.
//   XLEN / ILEN   : native PC and instruction widths.
//   RESET_PC      : default byte PC after reset.
//   NOP_INSTR     : canonical no-op (addi x0,x0,0).
//   fetch_entry_t : one fetched instruction together with its byte PC.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding {pc, instr} pairs between the
// instruction memory and decode.
//   clk, rst          : clock, synchronous active-high reset.
//   flush             : drop every entry and rewind both pointers.
//   push, wr_pc,
//   wr_instr          : enqueue one entry at the write pointer.
//   pop               : dequeue the head entry.
//   count             : occupancy, 0..BUF_DEPTH.
//   head_pc,
//   head_instr        : head entry, straight from storage registers.
// The caller guarantees push only when not full (or when popping in the
// same cycle) and pop only when not empty.
module fetch_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] wr_pc,
  input  logic [INST_WIDTH-1:0] wr_instr,
  output logic [1:0]            count,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [INST_WIDTH-1:0] head_instr
);

  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q,  count_d;

  logic [ADDR_WIDTH-1:0] pc_mem_q    [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d    [BUF_DEPTH];
  logic [INST_WIDTH-1:0] instr_mem_q [BUF_DEPTH];
  logic [INST_WIDTH-1:0] instr_mem_d [BUF_DEPTH];

  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    do_push = push & ~flush;
    do_pop  = pop  & ~flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      pc_mem_d[i]    = pc_mem_q[i];
      instr_mem_d[i] = instr_mem_q[i];
    end
    if (do_push) begin
      pc_mem_d[wr_ptr_q]    = wr_pc;
      instr_mem_d[wr_ptr_q] = wr_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates its visibility.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      pc_mem_q[i]    <= pc_mem_d[i];
      instr_mem_q[i] <= instr_mem_d[i];
    end
  end

  assign count      = count_q;
  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage in front of a combinational instruction memory.
//   clk, rst        : clock, synchronous active-high reset.
//   imem_addr       : word address {2'b00, pc[ADDR_WIDTH-1:2]}.
//   imem_rdata      : instruction returned for imem_addr in the same cycle.
//   redirect_valid,
//   redirect_pc     : taken branch/jump; flushes the buffer and reloads pc
//                     (target bits [1:0] are ignored).
//   dec_valid,
//   dec_ready       : valid/ready handshake toward decode.
//   dec_instr,
//   dec_pc,
//   dec_pc_plus4    : head instruction, its byte PC and PC+4.
// Every cycle the instruction at pc is captured into the buffer unless the
// buffer is full and not draining, or a redirect is in progress.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = riscv_pkg::XLEN,
  parameter int unsigned           INST_WIDTH = riscv_pkg::ILEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(riscv_pkg::RESET_PC),
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [INST_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [ADDR_WIDTH-1:0] dec_pc_plus4
);

  import riscv_pkg::*;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;
  logic                  unused_redirect_lsb;

  // Alignment bits of the target are dropped by construction.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign dec_valid = (count != 2'd0);
  assign imem_addr = {2'b00, pc_q[ADDR_WIDTH-1:2]};

  // A redirect suppresses both sides of the buffer in the cycle it is seen;
  // a full buffer may still accept a new entry when the head drains.
  always_comb begin
    pop  = dec_valid & dec_ready & ~redirect_valid;
    push = ~redirect_valid & ((count < 2'(BUF_DEPTH)) | pop);

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .wr_pc      (pc_q),
    .wr_instr   (imem_rdata),
    .count      (count),
    .head_pc    (dec_pc),
    .head_instr (dec_instr)
  );

  assign dec_pc_plus4 = dec_pc + ADDR_WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized
// ready/redirect/reset traffic. The driver predicts the in-order stream of
// {pc, instr} that decode must receive after every reset or redirect; a
// separate negedge monitor pops that stream on every accepted handshake.
module tb_fetch_unit;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: default reset PC, driven by the scoreboarded stimulus.
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;

  // DUT 2: reset PC at the top of the address space, free running.
  logic        rst2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        dec_valid2;
  logic [31:0] dec_instr2;
  logic [31:0] dec_pc2;
  logic [31:0] dec_pc_plus4_2;

  logic [31:0] mem [256];

  assign imem_rdata  = mem[imem_addr[7:0]];
  assign imem_rdata2 = ~imem_addr2;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .BUF_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus4   (dec_pc_plus4)
  );

  fetch_unit #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (32'hFFFF_FFFC),
    .BUF_DEPTH  (2)
  ) dut_wrap (
    .clk            (clk),
    .rst            (rst2),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .dec_valid      (dec_valid2),
    .dec_ready      (1'b1),
    .dec_instr      (dec_instr2),
    .dec_pc         (dec_pc2),
    .dec_pc_plus4   (dec_pc_plus4_2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: fetch proceeds sequentially from the last target.
  fetch_entry_t exp_q[$];
  logic [31:0]  next_pc;

  function automatic void refill();
    fetch_entry_t e;
    while (exp_q.size() < 16) begin
      e.pc    = next_pc;
      e.instr = mem[next_pc[9:2]];
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] target);
    exp_q.delete();
    next_pc = {target[31:2], 2'b00};
    refill();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  logic         armed     = 1'b0;
  logic         f1        = 1'b0;
  logic         hold_pend = 1'b0;
  logic [31:0]  hold_pc, hold_instr;

  always @(negedge clk) begin
    logic         flushing;
    fetch_entry_t e;
    if (armed) begin
      // Outside a one-cycle window after a flush the buffer is never empty.
      if (f1) check("valid_after_flush", dec_valid, 1'b0);
      else    check("valid_sustained", dec_valid, 1'b1);
      if (hold_pend) begin
        check("hold_pc", dec_pc, hold_pc);
        check("hold_instr", dec_instr, hold_instr);
      end
    end
    flushing = rst | redirect_valid;
    if (armed && !flushing && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        check("stream_underrun", dec_pc, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check("dec_pc", dec_pc, e.pc);
        check("dec_instr", dec_instr, e.instr);
        check("dec_pc_plus4", dec_pc_plus4, e.pc + 32'd4);
      end
    end
    hold_pend  = armed & dec_valid & ~dec_ready & ~flushing;
    hold_pc    = dec_pc;
    hold_instr = dec_instr;
    f1         = flushing;
    if (rst) armed = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0030_0113;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h00C0_0193;
    mem[3] = 32'h4031_00B3;

    rst = 1'b1; rst2 = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    restart(RESET_PC);
    step();
    check("rst_valid", dec_valid, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("wrap_rst_valid", dec_valid2, 1'b0);
    check("wrap_rst_imem_addr", imem_addr2, 32'h3FFF_FFFF);
    rst = 1'b0; rst2 = 1'b0;

    // Free run from reset.
    for (int k = 1; k <= 3; k++) begin
      step();
      check("run_imem_addr", imem_addr, 32'(k));
      if (k == 1) begin
        check("run_first_valid", dec_valid, 1'b1);
        check("run_first_pc", dec_pc, 32'h0);
        check("wrap_pc", dec_pc2, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", dec_pc_plus4_2, 32'h0);
        check("wrap_instr", dec_instr2, ~32'h3FFF_FFFF);
      end
      if (k == 2) begin
        check("wrap_next_pc", dec_pc2, 32'h0);
        check("wrap_next_instr", dec_instr2, ~32'h0);
        check("wrap_next_plus4", dec_pc_plus4_2, 32'h4);
      end
    end

    // Back-pressure: head is pc 0x8, buffer fills, pc parks at 0x10.
    dec_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("stall_imem_addr", imem_addr, 32'h4);
      check("stall_pc", dec_pc, 32'h8);
      check("stall_instr", dec_instr, 32'h00C0_0193);
    end
    dec_ready = 1'b1;
    step();
    check("resume_pc", dec_pc, 32'hC);
    check("resume_instr", dec_instr, 32'h4031_00B3);

    // Redirect into a full buffer.
    dec_ready = 1'b0;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h44; restart(32'h44);
    step();
    redirect_valid = 1'b0; dec_ready = 1'b1;
    check("redir_valid", dec_valid, 1'b0);
    check("redir_imem_addr", imem_addr, 32'h11);
    step();
    check("redir_tgt_valid", dec_valid, 1'b1);
    check("redir_tgt_pc", dec_pc, 32'h44);
    check("redir_tgt_instr", dec_instr, mem[17]);

    // Misaligned then back-to-back redirect: second target wins.
    redirect_valid = 1'b1; redirect_pc = 32'h4B; restart(32'h4B);
    step();
    redirect_pc = 32'h70; restart(32'h70);
    step();
    redirect_valid = 1'b0;
    check("b2b_valid", dec_valid, 1'b0);
    check("b2b_imem_addr", imem_addr, 32'h1C);
    step();
    check("b2b_pc", dec_pc, 32'h70);
    check("b2b_instr", dec_instr, mem[28]);

    // Reset while full and stalled.
    dec_ready = 1'b0;
    step(); step(); step();
    rst = 1'b1; restart(RESET_PC);
    step();
    rst = 1'b0;
    check("mid_rst_valid", dec_valid, 1'b0);
    check("mid_rst_imem_addr", imem_addr, 32'h0);
    dec_ready = 1'b1;
    step();
    check("mid_rst_pc", dec_pc, 32'h0);
    check("mid_rst_instr", dec_instr, 32'h0030_0113);

    // Reset takes priority over a simultaneous redirect.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; restart(RESET_PC);
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    check("rst_over_redir_addr", imem_addr, 32'h0);
    step();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99);
      rst = 1'b0;
      redirect_valid = 1'b0;
      dec_ready = ($urandom_range(99) < 65);
      if (r < 2) begin
        rst = 1'b1;
        restart(RESET_PC);
      end else if (r < 10) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'($urandom_range(1023));
        restart(redirect_pc);
      end
      refill();
      step();
    end

    rst = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      refill();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
